// File: rtl/pipelined_carry_chain_adder.sv
// Pipelined CARRY4-style prop/gen carry chain with input skew, output deskew and a valid/ready handshake.
// Define CARRY_CHAIN_COUT_EN to add a registered carry-out port (cout) aligned with sum.
module pipelined_carry_chain_adder #(
   parameter int W        = 38,
   parameter int SEG_BITS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] prop,
   input  logic [W-1:0] gen,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum
`ifdef CARRY_CHAIN_COUT_EN
   ,
   output logic         cout
`endif
);
   localparam int NSEG = (W + SEG_BITS - 1) / SEG_BITS;

   logic            en_s;
   logic            vlast_in_s;
   logic [NSEG-1:0] v_r;
   logic            carry_s [NSEG];

   assign en_s       = !v_r[NSEG-1] || out_ready;
   assign in_ready   = en_s;
   assign out_valid  = v_r[NSEG-1];
   assign carry_s[0] = cin;

   // valid shift register: one slot per pipeline stage, bubbles travel as empty slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= '0;
      end else if (en_s) begin
         v_r[0] <= in_valid;
         for (int i = 1; i < NSEG; i++) begin
            v_r[i] <= v_r[i-1];
         end
      end
   end

   // valid bit that lands in the output slot on the next enabled edge
   if (NSEG == 1) begin : g_vl_single
      assign vlast_in_s = in_valid;
   end else begin : g_vl_multi
      assign vlast_in_s = v_r[NSEG-2];
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      localparam int LO = k * SEG_BITS;
      localparam int SW = ((W - LO) < SEG_BITS) ? (W - LO) : SEG_BITS;
      localparam int DD = NSEG - k;

      logic [SW-1:0] p_s;
      logic [SW-1:0] g_s;
      logic [SW-1:0] s_s;
      logic [SW-1:0] res_r [DD];

      function automatic logic [SW-1:0] chain_sum(input logic [SW-1:0] p, input logic [SW-1:0] g,
                                                   input logic c0);
         logic c;
         c         = c0;
         chain_sum = '0;
         for (int i = 0; i < SW; i++) begin
            chain_sum[i] = p[i] ^ c;
            c            = p[i] ? c : g[i];
         end
      endfunction

      function automatic logic chain_cout(input logic [SW-1:0] p, input logic [SW-1:0] g,
                                          input logic c0);
         logic c;
         c = c0;
         for (int i = 0; i < SW; i++) begin
            c = p[i] ? c : g[i];
         end
         return c;
      endfunction

      if (k == 0) begin : g_noskew
         assign p_s = prop[LO +: SW];
         assign g_s = gen[LO +: SW];
      end else begin : g_skew
         logic [SW-1:0] pk_r [k];
         logic [SW-1:0] gk_r [k];

         // input skew: segment k operands wait k cycles for their incoming carry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < k; d++) begin
                  pk_r[d] <= '0;
                  gk_r[d] <= '0;
               end
            end else if (en_s) begin
               pk_r[0] <= prop[LO +: SW];
               gk_r[0] <= gen[LO +: SW];
               for (int d = 1; d < k; d++) begin
                  pk_r[d] <= pk_r[d-1];
                  gk_r[d] <= gk_r[d-1];
               end
            end
         end

         assign p_s = pk_r[k-1];
         assign g_s = gk_r[k-1];
      end

      assign s_s = chain_sum(p_s, g_s, carry_s[k]);

      // stage register followed by deskew; the output-facing register is zeroed for empty slots
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int d = 0; d < DD; d++) begin
               res_r[d] <= '0;
            end
         end else if (en_s) begin
            res_r[0] <= s_s;
            for (int d = 1; d < DD; d++) begin
               res_r[d] <= res_r[d-1];
            end
            if (!vlast_in_s) begin
               res_r[DD-1] <= '0;
            end
         end
      end

      assign sum[LO +: SW] = res_r[DD-1];

      if (k < NSEG - 1) begin : g_carry
         logic co_r;

         // segment carry-out handed to the next stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               co_r <= 1'b0;
            end else if (en_s) begin
               co_r <= chain_cout(p_s, g_s, carry_s[k]);
            end
         end

         assign carry_s[k+1] = co_r;
      end
`ifdef CARRY_CHAIN_COUT_EN
      else begin : g_top_cout
         // top carry-out shares the output slot timing of the last segment
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cout <= 1'b0;
            end else if (en_s) begin
               cout <= vlast_in_s ? chain_cout(p_s, g_s, carry_s[k]) : 1'b0;
            end
         end
      end
`endif
   end

endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// Directed testbench for pipelined_carry_chain_adder (W=38/SEG_BITS=16 and W=20/SEG_BITS=8 instances).
`timescale 1ns/1ps
module tb_pipelined_carry_chain_adder;
   localparam int W  = 38;
   localparam int W2 = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, cin, out_valid, out_ready;
   logic [W-1:0]  prop, gen, sum;
   logic          iv2, ir2, c2, ov2, or2;
   logic [W2-1:0] p2, g2, s2;
`ifdef CARRY_CHAIN_COUT_EN
   logic          cout, cout2;
`endif

   logic [W:0]    exp_q [$];
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   pipelined_carry_chain_adder #(.W(W), .SEG_BITS(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .prop(prop), .gen(gen), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum)
`ifdef CARRY_CHAIN_COUT_EN
      , .cout(cout)
`endif
   );

   pipelined_carry_chain_adder #(.W(W2), .SEG_BITS(8)) dut20 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .prop(p2), .gen(g2), .cin(c2), .out_valid(ov2), .out_ready(or2),
      .sum(s2)
`ifdef CARRY_CHAIN_COUT_EN
      , .cout(cout2)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic v);
      prop     = a ^ b;
      gen      = a;
      cin      = c;
      in_valid = v;
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   task automatic test_reset();
      tick();
      tick();
      tests++;
      if (out_valid !== 1'b0 || sum !== {W{1'b0}} || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: out_valid=%b sum=%h in_ready=%b, expected 0 0 1", out_valid, sum, in_ready);
      end
`ifdef CARRY_CHAIN_COUT_EN
      tests++;
      if (cout !== 1'b0) begin
         fails++;
         $display("FAIL reset_cout: got %b expected 0", cout);
      end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      drive(38'h3F_FFFF_FFFF, 38'h1, 1'b0, 1'b1);
      tick();
      drive(38'h0, 38'h0, 1'b0, 1'b0);
      for (int cyc = 1; cyc < 3; cyc++) begin
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early cycle %0d: out_valid=%b expected 0", cyc, out_valid);
         end
         tick();
      end
      tests++;
      if (out_valid !== 1'b1 || sum !== 38'h0) begin
         fails++;
         $display("FAIL basic_result: out_valid=%b sum=%h expected 1 0", out_valid, sum);
      end
`ifdef CARRY_CHAIN_COUT_EN
      tests++;
      if (cout !== 1'b1) begin
         fails++;
         $display("FAIL basic_cout: got %b expected 1", cout);
      end
`endif
      tick();
      tests++;
      if (out_valid !== 1'b0 || sum !== 38'h0) begin
         fails++;
         $display("FAIL basic_drain: out_valid=%b sum=%h expected 0 0", out_valid, sum);
      end
   endtask

   task automatic test_stream();
      logic [W-1:0] a, b;
      logic         c;
      logic [W:0]   e;
      int           sent = 0;
      int           got  = 0;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 400 && got < 200; cyc++) begin
         if (out_valid === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+1){1'bx}};
            tests++;
            if (sum !== e[W-1:0] || cyc != got + 3) begin
               fails++;
               $display("FAIL stream word %0d: sum=%h at cycle %0d, expected %h at cycle %0d",
                        got, sum, cyc, e[W-1:0], got + 3);
            end
            got++;
         end
         if (sent < 200) begin
            a = W'({$urandom, $urandom});
            b = W'({$urandom, $urandom});
            c = 1'($urandom_range(0, 1));
            drive(a, b, c, 1'b1);
            exp_q.push_back(ref_add(a, b, c));
            sent++;
         end else begin
            drive(38'h0, 38'h0, 1'b0, 1'b0);
         end
         tick();
      end
      tests++;
      if (got != 200) begin
         fails++;
         $display("FAIL stream_count: got %0d results expected 200", got);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b, held;
      logic         c;
      logic [W:0]   e;
      int           sent = 0;
      int           got  = 0;
      int           stall = 0;
      bit           stall_done = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      held      = '0;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         if (stall > 0) begin
            tests++;
            if (out_valid !== 1'b1 || sum !== held) begin
               fails++;
               $display("FAIL stall_hold cycle %0d: out_valid=%b sum=%h expected 1 %h", cyc, out_valid, sum, held);
            end
            stall--;
            if (stall == 0) out_ready = 1'b1;
         end else if (out_valid === 1'b1 && !stall_done) begin
            held       = sum;
            stall      = 5;
            stall_done = 1'b1;
            out_ready  = 1'b0;
         end
         if (out_valid === 1'b1 && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+1){1'bx}};
            tests++;
            if (sum !== e[W-1:0]) begin
               fails++;
               $display("FAIL bp_word %0d: sum=%h expected %h", got, sum, e[W-1:0]);
            end
            got++;
         end
         if (sent < 10) begin
            a = W'({$urandom, $urandom});
            b = W'({$urandom, $urandom});
            c = 1'($urandom_range(0, 1));
            drive(a, b, c, 1'b1);
         end else begin
            drive(38'h0, 38'h0, 1'b0, 1'b0);
         end
         #1;
         if (!out_ready) begin
            tests++;
            if (in_ready !== 1'b0) begin
               fails++;
               $display("FAIL stall_in_ready cycle %0d: got %b expected 0", cyc, in_ready);
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(ref_add(a, b, c));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      tests++;
      if (got != 10 || !stall_done) begin
         fails++;
         $display("FAIL bp_count: got %0d results (stall seen %b) expected 10 (1)", got, stall_done);
      end
   endtask

   task automatic test_bubbles();
      bit           pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] a, b;
      logic [W:0]   e;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 9; cyc++) begin
         if (cyc >= 3) begin
            tests++;
            if (pat[cyc-3]) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : {(W+1){1'bx}};
               if (out_valid !== 1'b1 || sum !== e[W-1:0]) begin
                  fails++;
                  $display("FAIL bubble slot %0d: out_valid=%b sum=%h expected 1 %h", cyc - 3, out_valid, sum, e[W-1:0]);
               end
            end else if (out_valid !== 1'b0 || sum !== 38'h0) begin
               fails++;
               $display("FAIL bubble slot %0d: out_valid=%b sum=%h expected 0 0", cyc - 3, out_valid, sum);
            end
         end
         if (cyc < 6) begin
            a = 38'h12_3456_7800 + W'(cyc);
            b = 38'h0F_0F0F_0F0F;
            drive(a, b, 1'b0, pat[cyc]);
            if (pat[cyc]) exp_q.push_back(ref_add(a, b, 1'b0));
         end else begin
            drive(38'h0, 38'h0, 1'b0, 1'b0);
         end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(38'h2A_0000_0000 + W'(i), 38'h15_5555_5555, 1'b1, 1'b1);
         tick();
      end
      drive(38'h0, 38'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || sum !== 38'h0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL midreset_state: out_valid=%b sum=%h in_ready=%b expected 0 0 1", out_valid, sum, in_ready);
      end
      tick();
      rst_n = 1'b1;
      drive(38'd5, 38'd7, 1'b0, 1'b1);
      tick();
      drive(38'h0, 38'h0, 1'b0, 1'b0);
      for (int cyc = 1; cyc < 3; cyc++) begin
         tests++;
         if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_stale cycle %0d: out_valid=%b expected 0", cyc, out_valid);
         end
         tick();
      end
      tests++;
      if (out_valid !== 1'b1 || sum !== 38'd12) begin
         fails++;
         $display("FAIL midreset_new: out_valid=%b sum=%0d expected 1 12", out_valid, sum);
      end
   endtask

   task automatic test_partial_segment();
      or2 = 1'b1;
      p2  = 20'hFFFFF ^ 20'h00000; g2 = 20'hFFFFF; c2 = 1'b1; iv2 = 1'b1;
      tick();
      p2  = 20'h0FF00 ^ 20'h00100; g2 = 20'h0FF00; c2 = 1'b0; iv2 = 1'b1;
      tick();
      iv2 = 1'b0; p2 = '0; g2 = '0;
      tick();
      tests++;
      if (ov2 !== 1'b1 || s2 !== 20'h00000) begin
         fails++;
         $display("FAIL partial_wrap: out_valid=%b sum=%h expected 1 00000", ov2, s2);
      end
`ifdef CARRY_CHAIN_COUT_EN
      tests++;
      if (cout2 !== 1'b1) begin
         fails++;
         $display("FAIL partial_cout: got %b expected 1", cout2);
      end
`endif
      tick();
      tests++;
      if (ov2 !== 1'b1 || s2 !== 20'h10000) begin
         fails++;
         $display("FAIL partial_carry: out_valid=%b sum=%h expected 1 10000", ov2, s2);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(38'h0, 38'h0, 1'b0, 1'b0);
      iv2 = 1'b0; p2 = '0; g2 = '0; c2 = 1'b0; or2 = 1'b1;
      test_reset();
      test_basic();
      test_stream();
      test_backpressure();
      test_bubbles();
      test_reset_midstream();
      test_partial_segment();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
